// File: rtl/i2c_pkg.sv
// Shared FSM state type and bus-level constants for the I2C register target.
package i2c_pkg;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck
  } state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line, with rise/fall detection on the
// synchronized value.
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Idle bus level is high, so reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], line_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level_o = r_sync[SYNC_STAGES-1];
  assign rise_o  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign fall_o  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing a byte register file with an auto-incrementing pointer.
// Read transfers are compiled in only when I2C_TARGET_READ_EN is defined.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDRESS     = 7'h69,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_o,
  output logic [NUM_REGS*8-1:0]       regs_o,
  output logic                        wr_strobe_o,
  output logic [$clog2(NUM_REGS)-1:0] wr_index_o,
  output logic                        start_o,
  output logic                        stop_o,
  output logic                        busy_o
);

  localparam int unsigned PtrW = $clog2(NUM_REGS);

  logic w_scl_level, w_scl_rise, w_scl_fall;
  logic w_sda_level, w_sda_rise, w_sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk     (clk),
    .reset   (reset),
    .line_i  (scl_i),
    .level_o (w_scl_level),
    .rise_o  (w_scl_rise),
    .fall_o  (w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk     (clk),
    .reset   (reset),
    .line_i  (sda_i),
    .level_o (w_sda_level),
    .rise_o  (w_sda_rise),
    .fall_o  (w_sda_fall)
  );

  state_e                   r_state;
  logic [3:0]               r_bit_cnt;
  logic [7:0]               r_shift;
  logic [PtrW-1:0]          r_ptr;
  logic [NUM_REGS-1:0][7:0] r_regs;
  logic                     r_sda_o;
  logic                     r_wr_strobe;
  logic [PtrW-1:0]          r_wr_index;
  logic                     r_start;
  logic                     r_stop;
  logic                     r_busy;
`ifdef I2C_TARGET_READ_EN
  logic                     r_rw;
`endif

  logic w_start, w_stop, w_byte_done, w_addr_match, w_rw_ok;

  assign w_start      = w_scl_level & w_sda_fall;
  assign w_stop       = w_scl_level & w_sda_rise;
  assign w_byte_done  = (r_bit_cnt == 4'd8);
  assign w_addr_match = (r_shift[7:1] == ADDRESS);
`ifdef I2C_TARGET_READ_EN
  assign w_rw_ok      = 1'b1;
`else
  assign w_rw_ok      = ~r_shift[0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_regs      <= '0;
      r_sda_o     <= I2C_NACK;
      r_wr_strobe <= 1'b0;
      r_wr_index  <= '0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
      r_busy      <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      r_rw        <= 1'b0;
`endif
    end else begin
      r_wr_strobe <= 1'b0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
      if (w_start) begin
        r_state   <= StAddr;
        r_bit_cnt <= '0;
        r_start   <= 1'b1;
        r_sda_o   <= I2C_NACK;
      end else if (w_stop) begin
        r_state <= StIdle;
        r_stop  <= 1'b1;
        r_busy  <= 1'b0;
        r_sda_o <= I2C_NACK;
      end else begin
        unique case (r_state)
          StIdle: ;
          StAddr: begin
            if (w_scl_rise && !w_byte_done) begin
              r_shift   <= {r_shift[6:0], w_sda_level};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && w_byte_done) begin
              if (w_addr_match && w_rw_ok) begin
                r_sda_o <= I2C_ACK;
                r_busy  <= 1'b1;
                r_state <= StAddrAck;
`ifdef I2C_TARGET_READ_EN
                r_rw    <= r_shift[0];
`endif
              end else begin
                r_busy  <= 1'b0;
                r_state <= StIdle;
              end
            end
          end
          StAddrAck: begin
            if (w_scl_fall) begin
              r_bit_cnt <= '0;
`ifdef I2C_TARGET_READ_EN
              if (r_rw) begin
                r_shift <= r_regs[r_ptr];
                r_sda_o <= r_regs[r_ptr][7];
                r_ptr   <= r_ptr + 1'b1;
                r_state <= StRdata;
              end else
`endif
              begin
                r_sda_o <= I2C_NACK;
                r_state <= StPtr;
              end
            end
          end
          StPtr: begin
            if (w_scl_rise && !w_byte_done) begin
              r_shift   <= {r_shift[6:0], w_sda_level};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && w_byte_done) begin
              r_ptr   <= r_shift[PtrW-1:0];
              r_sda_o <= I2C_ACK;
              r_state <= StPtrAck;
            end
          end
          StWdata: begin
            if (w_scl_rise && !w_byte_done) begin
              r_shift   <= {r_shift[6:0], w_sda_level};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && w_byte_done) begin
              r_regs[r_ptr] <= r_shift;
              r_wr_strobe   <= 1'b1;
              r_wr_index    <= r_ptr;
              r_ptr         <= r_ptr + 1'b1;
              r_sda_o       <= I2C_ACK;
              r_state       <= StWdataAck;
            end
          end
          StPtrAck, StWdataAck: begin
            if (w_scl_fall) begin
              r_sda_o   <= I2C_NACK;
              r_bit_cnt <= '0;
              r_state   <= StWdata;
            end
          end
`ifdef I2C_TARGET_READ_EN
          StRdata: begin
            if (w_scl_rise && !w_byte_done) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (w_byte_done) begin
                r_sda_o <= I2C_NACK;
                r_state <= StRdataAck;
              end else begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_sda_o <= r_shift[6];
              end
            end
          end
          // A NACK leaves on the rise, so a fall here always follows a controller ACK.
          StRdataAck: begin
            if (w_scl_rise && (w_sda_level == I2C_NACK)) begin
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end else if (w_scl_fall) begin
              r_shift   <= r_regs[r_ptr];
              r_sda_o   <= r_regs[r_ptr][7];
              r_ptr     <= r_ptr + 1'b1;
              r_bit_cnt <= '0;
              r_state   <= StRdata;
            end
          end
`endif
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign sda_o       = r_sda_o;
  assign regs_o      = r_regs;
  assign wr_strobe_o = r_wr_strobe;
  assign wr_index_o  = r_wr_index;
  assign start_o     = r_start;
  assign stop_o      = r_stop;
  assign busy_o      = r_busy;

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter ADDRESS, default 7'h69: 7-bit target address.
REQ-002 SHALL have parameter NUM_REGS, default 8: register-file depth, power of two, 2..256.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, minimum 2.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port scl_i  input  1  bus SCL, asynchronous.
REQ-007 SHALL have port sda_i  input  1  bus SDA, asynchronous.
REQ-008 SHALL have port sda_o  output  1  open-drain SDA drive: 0 pulls low, 1 releases.
REQ-009 SHALL have port regs_o  output  NUM_REGS*8  flattened register file; reg n at bits [8n+7:8n].
REQ-010 SHALL have port wr_strobe_o  output  1  one-cycle pulse per committed write byte.
REQ-011 SHALL have port wr_index_o  output  clog2(NUM_REGS)  index of the committed register, valid with wr_strobe_o.
REQ-012 SHALL have port start_o  output  1  one-cycle pulse on each START or repeated START.
REQ-013 SHALL have port stop_o  output  1  one-cycle pulse on STOP.
REQ-014 SHALL have port busy_o  output  1  high from an addressed ACK until STOP, NACK, or mismatch.

Function
REQ-015 SHALL synchronize scl_i and sda_i through SYNC_STAGES flops; all edge detection SHALL use synchronized values only.
REQ-016 SHALL detect START when SDA falls while SCL is high, and STOP when SDA rises while SCL is high.
REQ-017 SHALL use states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-018 SHALL have START take priority over every other event: it enters ADDR from any state and clears the bit counter.
REQ-019 SHALL have STOP enter IDLE from any state and release sda_o in the same cycle.
REQ-020 SHALL sample data bits MSB-first on the synchronized SCL rising edge.
REQ-021 SHALL change sda_o only on the synchronized SCL falling edge.
REQ-022 ADDR: after 8 bits, if bits[7:1] equal ADDRESS, SHALL drive ACK low from the next SCL fall until the following SCL fall; otherwise SHALL go to IDLE without ACK.
REQ-023 SHALL never ACK address 7'h00 (general call), unless ADDRESS is set to 0.
REQ-024 For write transfers (R/W=0), the first byte after the address SHALL load the pointer with byte[clog2(NUM_REGS)-1:0], and SHALL be ACKed.
REQ-025 Each following write byte SHALL be written to regs[ptr] at the SCL fall that begins its ACK; wr_strobe_o and wr_index_o SHALL pulse in that cycle; the byte SHALL be ACKed; ptr SHALL then increment.
REQ-026 ptr SHALL wrap from NUM_REGS-1 to 0, both on write and on read.
REQ-027 For read transfers (R/W=1), at the SCL fall ending the address ACK, SHALL load the shifter with regs[ptr], drive its MSB, then increment ptr.
REQ-028 RDATA_ACK SHALL release SDA and sample the controller ACK on SCL rise: ACK (0) loads and drives the next byte; NACK (1) goes to IDLE.
REQ-029 A register SHALL NOT be written if START or STOP occurs before its 8th bit completes.

Reset
REQ-030 Reset SHALL asynchronously set state=IDLE, sda_o=1, ptr=0, regs_o=0, wr_strobe_o=0, wr_index_o=0, start_o=0, stop_o=0, busy_o=0, and clear the synchronizers to 1.
REQ-031 Reset asserted mid-transfer SHALL release SDA immediately, and the block SHALL ignore the bus until the next START.

Configuration
REQ-032 Macro I2C_TARGET_READ_EN defined SHALL compile in read support (RDATA, RDATA_ACK, REQ-027, REQ-028).
REQ-033 Without I2C_TARGET_READ_EN, an address match with R/W=1 SHALL NOT be ACKed, the state SHALL return to IDLE, and no read logic SHALL be present.

Structure
REQ-034 Package i2c_pkg SHALL hold the state enum and the constants I2C_ACK=1'b0 and I2C_NACK=1'b1.
REQ-035 Sub-module i2c_sync_edge SHALL implement the synchronizer and rise/fall detection for one line, and SHALL be instantiated once for SCL and once for SDA.

Verification
REQ-036 Write 0xD2, 0x03, 0xA5, then STOP -> three ACKs; regs[3]=0xA5; one wr_strobe_o with wr_index_o=3; stop_o pulse.
REQ-037 Write 0xD2, 0x07, 0x11, 0x22 -> regs[7]=0x11 and regs[0]=0x22 (wrap).
REQ-038 Write 0xD2, 0x02; repeated START; 0xD3; read two bytes with ACK then NACK -> SDA carries regs[2] then regs[3]; SDA released after the NACK.
REQ-039 Send address byte 0xA0 -> no ACK; busy_o stays 0; following bytes are ignored.
REQ-040 Assert reset during the ACK low of a write byte -> sda_o=1 in the same cycle; regs_o=0.
REQ-041 Build without I2C_TARGET_READ_EN and send 0xD3 -> SDA stays high during the ACK bit; state=IDLE.
